ext_bus_sched: RTL and testbench
================================

Name: ext_bus_sched

Overview:
- Time-slot scheduler and arbiter for the single shared external memory bus (address, data in/out, cale, cs, wr).
- Generates the 4-phase frame counter.
- Grants CPU-data slots to the CPU or OAM-DMA requester, and the two PPU slots to the VRAM fetcher.
- Drives registered pad outputs and returns read data to each requester with a valid pulse.

Parameters:
- PPU_HI, 3'b100, upper address bits prepended to ppu_addr.
- DMA_PRIO, 1, 1: DMA wins simultaneous DMA/CPU requests; 0: CPU wins.
- IDLE_ADDR, 16'hFFFF, value on a during an ungranted CPU/DMA slot.

Ports:
- clk  in  1  system clock (4 MHz)
- rstn  in  1  reset; synchronous, active-low
- ct  out  2  current phase 0..3
- cpu_req  in  1  CPU access request (level)
- cpu_we  in  1  1 = write
- cpu_addr  in  16  CPU address
- cpu_wdata  in  8  CPU write data
- cpu_gnt  out  1  CPU request accepted this cycle
- cpu_rvalid  out  1  cpu_rdata updated this cycle
- cpu_rdata  out  8  CPU read data
- dma_req  in  1  DMA read request
- dma_addr  in  16  DMA source address
- dma_gnt  out  1  DMA request accepted this cycle
- dma_rvalid  out  1  dma_rdata updated this cycle
- dma_rdata  out  8  DMA read data
- ppu_req  in  1  VRAM read request
- ppu_addr  in  13  VRAM offset
- ppu_gnt  out  1  PPU request accepted this cycle
- ppu_rvalid  out  1  ppu_rdata updated this cycle
- ppu_rdata  out  8  PPU read data
- a  out  16  pad address
- dout  out  8  pad write data
- din  in  8  pad read data
- doe  out  1  1 = chip drives data pads
- wr  out  1  write strobe
- cale  out  1  cartridge address latch enable
- cs  out  1  cartridge chip select

Behaviour:
Reset:
- While rstn=0 at a rising edge: ph=0, no grant latched.
- Pads reset to a=IDLE_ADDR, dout=8'hFF, doe=0, wr=0, cale=0, cs=0.
- All rdata reset to 8'hFF; all gnt/rvalid are 0.
- Reset asserted mid-frame aborts any in-flight access; no rvalid is issued for it.

Phase counter:
- ct=ph; increments by 1 every cycle and wraps 3 to 0.
- Frame = 4 cycles. Phase-N cycle means ph==N.

Handshake:
- Every accept is a cycle where req=1 and gnt=1; it takes effect at the closing edge of that cycle.
- Requesters hold addr/we/wdata stable while req=1 and may change them right after an accept.

CPU/DMA arbitration (phase 3):
- cpu_gnt and dma_gnt are combinational and only ever 1 in phase 3.
- If only one requests, that one is granted.
- If both request, DMA_PRIO decides; the loser keeps waiting with gnt=0.
- At the closing edge of phase 3, the scheduler latches the grant id, address, we and wdata, plus cart = (addr<=16'h7FFF) or (16'hA000<=addr<=16'hBFFF).

PPU slots (phases 0 and 2):
- ppu_gnt = ppu_req when ph is 0 or 2.
- On accept, {PPU_HI, ppu_addr} is latched for the following phase (1 or 3).

Pad outputs:
- All are flops, updated on the edge entering the phase; no combinational path from request inputs to pads.
- Phase 0: a = latched CPU/DMA address, cale = grant & cart; doe=wr=cs=0, dout=FF.
- Phase 1 and phase 3: a = latched PPU address if a PPU grant occurred, else IDLE_ADDR; cale=cs=doe=wr=0.
- Phase 2: a = latched address, cs = grant & cart, wr = doe = grant & we, dout = we ? wdata : FF; cale=0.
- With no grant, phases 0 and 2 drive a=IDLE_ADDR and all strobes 0.

Read return:
- din is sampled at the closing edge of phase 1, 2 and 3.
- End of phase 1 and end of phase 3: if a PPU grant is pending, load ppu_rdata and pulse ppu_rvalid for one cycle (phase 2 and phase 0 respectively).
- End of phase 2: if a CPU/DMA read is granted, load that requester's rdata and pulse its rvalid in phase 3.
- A write completes silently, with no rvalid.
- rdata holds its value until the next load.

Timing and throughput:
- CPU/DMA latency: accept at end of phase 3 of frame k; rvalid in phase 3 of frame k+1, the same cycle as the next possible gnt.
- Throughput: one CPU/DMA access per frame and two PPU reads per frame.

Edge cases:
- Dropping req before an accept cancels nothing; no state change.
- Dropping req after an accept does not abort the access.
- The first frame after reset always has an idle phase 0.

Test Plan:
1. Reset: hold rstn=0 for 3 cycles mid-frame, then release -> ct=0,1,2,3,0…; pads idle (a=FFFF, cs=cale=wr=doe=0); no rvalid.
2. CPU read: cpu_req=1, we=0, addr=0x0150 at phase 3, din=0x3C in phase 2 -> cpu_gnt=1 in phase 3; phase 0 a=0150 cale=1; phase 2 cs=1 wr=0; cpu_rvalid in next phase 3 with rdata=0x3C.
3. CPU write to WRAM: addr=0xC010, wdata=0xA5 -> phase 0 cale=0; phase 2 a=C010, dout=A5, wr=doe=1, cs=0; no cpu_rvalid.
4. Contention: cpu_req and dma_req both held, DMA_PRIO=1 -> dma_gnt in frame k, CPU waits; cpu_gnt only after dma_req drops. DMA_PRIO=0 -> reverse order.
5. PPU: ppu_req=1, ppu_addr=0x1800 continuously, din=0x11 in phase 1 and 0x22 in phase 3 -> a=0x9800 in phases 1 and 3; ppu_rvalid in phase 2 (0x11) and phase 0 (0x22).
6. Back-to-back CPU reads from 0x4000 then 0x4001 with req held -> gnt in consecutive phase-3 cycles; rvalid in the same phase-3 cycle as the second gnt.

Source files
------------

// File: rtl/ext_bus_if.sv
// ext_bus_if: requester handshakes (CPU, OAM-DMA, PPU), the phase counter
// and the external memory pads of the shared bus.
//   slave  : the scheduler side (drives grants, read returns, pads, ct)
//   master : the requester / board side (drives requests and din)
interface ext_bus_if;
    logic [1:0]  ct;

    logic        cpu_req;
    logic        cpu_we;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic        cpu_gnt;
    logic        cpu_rvalid;
    logic [7:0]  cpu_rdata;

    logic        dma_req;
    logic [15:0] dma_addr;
    logic        dma_gnt;
    logic        dma_rvalid;
    logic [7:0]  dma_rdata;

    logic        ppu_req;
    logic [12:0] ppu_addr;
    logic        ppu_gnt;
    logic        ppu_rvalid;
    logic [7:0]  ppu_rdata;

    logic [15:0] a;
    logic [7:0]  dout;
    logic [7:0]  din;
    logic        doe;
    logic        wr;
    logic        cale;
    logic        cs;

    modport slave (
        output ct,
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_gnt, cpu_rvalid, cpu_rdata,
        input  dma_req, dma_addr,
        output dma_gnt, dma_rvalid, dma_rdata,
        input  ppu_req, ppu_addr,
        output ppu_gnt, ppu_rvalid, ppu_rdata,
        output a, dout, doe, wr, cale, cs,
        input  din
    );

    modport master (
        input  ct,
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_gnt, cpu_rvalid, cpu_rdata,
        output dma_req, dma_addr,
        input  dma_gnt, dma_rvalid, dma_rdata,
        output ppu_req, ppu_addr,
        input  ppu_gnt, ppu_rvalid, ppu_rdata,
        input  a, dout, doe, wr, cale, cs,
        output din
    );
endinterface

// File: rtl/ext_bus_sched.sv
// ext_bus_sched: 4-phase time-slot scheduler for the shared external bus.
//   clk  : system clock
//   rstn : synchronous active-low reset
//   bus  : ext_bus_if.slave -- phase counter ct, CPU/DMA/PPU request and
//          read-return channels, registered pad outputs, din pad input.
// Frame layout: phase 3 grants one CPU/DMA access (executed in phases 0/2 of
// the next frame), phases 0 and 2 grant PPU reads (executed in phases 1/3).
module ext_bus_sched #(
    parameter logic [2:0]  PPU_HI    = 3'b100,
    parameter bit          DMA_PRIO  = 1'b1,
    parameter logic [15:0] IDLE_ADDR = 16'hFFFF
) (
    input  logic       clk,
    input  logic       rstn,
    ext_bus_if.slave   bus
);

    typedef struct packed {
        logic        vld;
        logic        id;     // 0 = CPU, 1 = DMA
        logic [15:0] addr;
        logic        we;
        logic [7:0]  wdata;
        logic        cart;
    } acc_t;

    typedef struct packed {
        logic [15:0] a;
        logic [7:0]  dout;
        logic        doe;
        logic        wr;
        logic        cale;
        logic        cs;
    } pad_t;

    localparam pad_t PAD_IDLE = '{a: IDLE_ADDR, dout: 8'hFF, doe: 1'b0,
                                  wr: 1'b0, cale: 1'b0, cs: 1'b0};

    function automatic logic is_cart(input logic [15:0] ad);
        return (ad <= 16'h7FFF) || ((ad >= 16'hA000) && (ad <= 16'hBFFF));
    endfunction

    logic [1:0]  ph_q, ph_d;
    acc_t        acc_q, acc_d;
    logic        ppu_vld_q, ppu_vld_d;
    logic [15:0] ppu_a_q, ppu_a_d;
    pad_t        pad_q, pad_d;
    logic        cpu_rv_q, cpu_rv_d;
    logic        dma_rv_q, dma_rv_d;
    logic        ppu_rv_q, ppu_rv_d;
    logic [7:0]  cpu_rd_q, cpu_rd_d;
    logic [7:0]  dma_rd_q, dma_rd_d;
    logic [7:0]  ppu_rd_q, ppu_rd_d;

    logic        cpu_gnt, dma_gnt, ppu_gnt;
    logic [15:0] sel_addr;

    always_comb begin
        ph_d     = ph_q + 2'd1;
        acc_d    = acc_q;
        ppu_vld_d = ppu_vld_q;
        ppu_a_d  = ppu_a_q;
        pad_d    = PAD_IDLE;
        cpu_rd_d = cpu_rd_q;
        dma_rd_d = dma_rd_q;
        ppu_rd_d = ppu_rd_q;

        // Grants are masked in reset so nothing looks accepted on an edge
        // that reset will override anyway.
        cpu_gnt  = rstn && (ph_q == 2'd3) && bus.cpu_req && (!bus.dma_req || !DMA_PRIO);
        dma_gnt  = rstn && (ph_q == 2'd3) && bus.dma_req && (!bus.cpu_req || DMA_PRIO);
        ppu_gnt  = rstn && !ph_q[0] && bus.ppu_req;
        sel_addr = dma_gnt ? bus.dma_addr : bus.cpu_addr;

        // CPU/DMA slot: latch the winner at the end of phase 3; no winner
        // leaves the next frame idle.
        if (ph_q == 2'd3) begin
            acc_d.vld   = cpu_gnt || dma_gnt;
            acc_d.id    = dma_gnt;
            acc_d.addr  = sel_addr;
            acc_d.we    = cpu_gnt && bus.cpu_we;
            acc_d.wdata = bus.cpu_wdata;
            acc_d.cart  = is_cart(sel_addr);
        end

        // PPU slots: phases 0 and 2 latch an address for the following phase.
        if (!ph_q[0]) begin
            ppu_vld_d = ppu_gnt;
            ppu_a_d   = {PPU_HI, bus.ppu_addr};
        end

        // Pads are computed from the state valid in the phase being entered,
        // so the address granted at this edge reaches the pins immediately.
        case (ph_d)
            2'd0: if (acc_d.vld) begin
                pad_d.a    = acc_d.addr;
                pad_d.cale = acc_d.cart;
            end
            2'd2: if (acc_d.vld) begin
                pad_d.a    = acc_d.addr;
                pad_d.cs   = acc_d.cart;
                pad_d.wr   = acc_d.we;
                pad_d.doe  = acc_d.we;
                pad_d.dout = acc_d.we ? acc_d.wdata : 8'hFF;
            end
            default: if (ppu_vld_d) pad_d.a = ppu_a_d;
        endcase

        // Read return: PPU data at the end of phases 1/3, CPU/DMA at phase 2.
        ppu_rv_d = ph_q[0] && ppu_vld_q;
        cpu_rv_d = (ph_q == 2'd2) && acc_q.vld && !acc_q.we && !acc_q.id;
        dma_rv_d = (ph_q == 2'd2) && acc_q.vld && !acc_q.we &&  acc_q.id;
        if (ppu_rv_d) ppu_rd_d = bus.din;
        if (cpu_rv_d) cpu_rd_d = bus.din;
        if (dma_rv_d) dma_rd_d = bus.din;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            ph_q      <= 2'd0;
            acc_q     <= '0;
            ppu_vld_q <= 1'b0;
            ppu_a_q   <= IDLE_ADDR;
            pad_q     <= PAD_IDLE;
            cpu_rv_q  <= 1'b0;
            dma_rv_q  <= 1'b0;
            ppu_rv_q  <= 1'b0;
            cpu_rd_q  <= 8'hFF;
            dma_rd_q  <= 8'hFF;
            ppu_rd_q  <= 8'hFF;
        end else begin
            ph_q      <= ph_d;
            acc_q     <= acc_d;
            ppu_vld_q <= ppu_vld_d;
            ppu_a_q   <= ppu_a_d;
            pad_q     <= pad_d;
            cpu_rv_q  <= cpu_rv_d;
            dma_rv_q  <= dma_rv_d;
            ppu_rv_q  <= ppu_rv_d;
            cpu_rd_q  <= cpu_rd_d;
            dma_rd_q  <= dma_rd_d;
            ppu_rd_q  <= ppu_rd_d;
        end
    end

    assign bus.ct         = ph_q;
    assign bus.cpu_gnt    = cpu_gnt;
    assign bus.dma_gnt    = dma_gnt;
    assign bus.ppu_gnt    = ppu_gnt;
    assign bus.cpu_rvalid = cpu_rv_q;
    assign bus.dma_rvalid = dma_rv_q;
    assign bus.ppu_rvalid = ppu_rv_q;
    assign bus.cpu_rdata  = cpu_rd_q;
    assign bus.dma_rdata  = dma_rd_q;
    assign bus.ppu_rdata  = ppu_rd_q;
    assign bus.a          = pad_q.a;
    assign bus.dout       = pad_q.dout;
    assign bus.doe        = pad_q.doe;
    assign bus.wr         = pad_q.wr;
    assign bus.cale       = pad_q.cale;
    assign bus.cs         = pad_q.cs;

endmodule

// File: tb/tb_ext_bus_sched.sv
// Bench for ext_bus_sched: u0 (DMA priority) is checked every cycle against
// an event-scheduling reference model; u1 (CPU priority) covers the reverse
// arbitration order. Directed table vectors and sequences precede a random run.
module tb_ext_bus_sched;
    localparam int N = 8192;

    logic clk;
    logic rstn;

    ext_bus_if bi0();
    ext_bus_if bi1();

    ext_bus_sched #(.PPU_HI(3'b100), .DMA_PRIO(1'b1), .IDLE_ADDR(16'hFFFF))
        u0 (.clk(clk), .rstn(rstn), .bus(bi0.slave));
    ext_bus_sched #(.PPU_HI(3'b100), .DMA_PRIO(1'b0), .IDLE_ADDR(16'hFFFF))
        u1 (.clk(clk), .rstn(rstn), .bus(bi1.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s t=%0t act=%h req=%h", nm, $time, act, req);
        end
    endtask

    // ---------------- reference model (u0) ----------------
    typedef struct {
        logic [15:0] a;
        logic [7:0]  dout;
        logic        doe, wr, cale, cs;
        logic        cpu_rv, dma_rv, ppu_rv;
    } exp_t;

    exp_t       expq [N];
    logic [7:0] din_hist [N];
    int         c;
    bit         model_en = 0;
    bit         rst_edge = 0;
    logic [7:0] m_cpu, m_dma, m_ppu;

    function automatic exp_t idle_e();
        exp_t e;
        e.a = 16'hFFFF; e.dout = 8'hFF;
        e.doe = 0; e.wr = 0; e.cale = 0; e.cs = 0;
        e.cpu_rv = 0; e.dma_rv = 0; e.ppu_rv = 0;
        return e;
    endfunction

    function automatic bit cart_of(input logic [15:0] ad);
        return (ad <= 16'h7FFF) || (ad >= 16'hA000 && ad <= 16'hBFFF);
    endfunction

    initial forever begin
        @(posedge clk);
        rst_edge = !rstn;
    end

    initial begin : monitor
        exp_t e;
        int ph, k1, k3, k4;
        bit cg, dg, pg, we, ct_c;
        logic [15:0] ad;
        forever begin
            @(negedge clk);
            if (!rstn) begin
                chk("rst_gnt", {bi0.cpu_gnt, bi0.dma_gnt, bi0.ppu_gnt}, 0);
                if (rst_edge) begin
                    chk("rst_pads", {bi0.a, bi0.dout, bi0.doe, bi0.wr, bi0.cale, bi0.cs},
                        {16'hFFFF, 8'hFF, 4'b0000});
                    chk("rst_ct", bi0.ct, 0);
                    chk("rst_rv", {bi0.cpu_rvalid, bi0.dma_rvalid, bi0.ppu_rvalid}, 0);
                    chk("rst_rdata", {bi0.cpu_rdata, bi0.dma_rdata, bi0.ppu_rdata}, 24'hFFFFFF);
                    model_en = 1;
                end
            end else if (model_en) begin
                if (rst_edge) begin
                    c = 0;
                    for (int i = 0; i < N; i++) expq[i] = idle_e();
                    m_cpu = 8'hFF; m_dma = 8'hFF; m_ppu = 8'hFF;
                end else c++;
                ph = c % 4;
                e = expq[c % N];
                expq[c % N] = idle_e();
                chk("ct", bi0.ct, ph);
                chk("pads", {bi0.a, bi0.dout, bi0.doe, bi0.wr, bi0.cale, bi0.cs},
                    {e.a, e.dout, e.doe, e.wr, e.cale, e.cs});
                chk("rvalid", {bi0.cpu_rvalid, bi0.dma_rvalid, bi0.ppu_rvalid},
                    {e.cpu_rv, e.dma_rv, e.ppu_rv});
                // Every read return carries din of the immediately preceding cycle.
                if (e.cpu_rv) m_cpu = din_hist[(c + N - 1) % N];
                if (e.dma_rv) m_dma = din_hist[(c + N - 1) % N];
                if (e.ppu_rv) m_ppu = din_hist[(c + N - 1) % N];
                chk("rdata", {bi0.cpu_rdata, bi0.dma_rdata, bi0.ppu_rdata}, {m_cpu, m_dma, m_ppu});

                // DMA wins ties for u0.
                cg = (ph == 3) && bi0.cpu_req && !bi0.dma_req;
                dg = (ph == 3) && bi0.dma_req;
                pg = (ph == 0 || ph == 2) && bi0.ppu_req;
                chk("gnt", {bi0.cpu_gnt, bi0.dma_gnt, bi0.ppu_gnt}, {cg, dg, pg});
                din_hist[c % N] = bi0.din;

                k1 = (c + 1) % N; k3 = (c + 3) % N; k4 = (c + 4) % N;
                if (cg || dg) begin
                    ad   = dg ? bi0.dma_addr : bi0.cpu_addr;
                    we   = cg && bi0.cpu_we;
                    ct_c = cart_of(ad);
                    expq[k1].a = ad; expq[k1].cale = ct_c;
                    expq[k3].a = ad; expq[k3].cs = ct_c;
                    expq[k3].wr = we; expq[k3].doe = we;
                    expq[k3].dout = we ? bi0.cpu_wdata : 8'hFF;
                    if (!we) begin
                        if (cg) expq[k4].cpu_rv = 1;
                        else    expq[k4].dma_rv = 1;
                    end
                end
                if (pg) begin
                    expq[k1].a = {3'b100, bi0.ppu_addr};
                    expq[(c + 2) % N].ppu_rv = 1;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Advance at least one cycle, then until the cycle of phase p begins.
    task automatic align(input logic [1:0] p);
        int n;
        n = 0;
        step();
        while (bi0.ct !== p && n < 8) begin
            step();
            n++;
        end
        chk("align", bi0.ct, p);
    endtask

    typedef struct {
        logic        we;
        logic [15:0] addr;
        logic [7:0]  wdata;
        logic [7:0]  din;
        logic        cale, cs, rv;
    } vec_t;

    vec_t tv [8];

    initial begin : watchdog
        #1000000;
        bad++;
        $display("FAIL watchdog t=%0t", $time);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin : main
        bit cacc, dacc, pacc;
        int rcnt;

        tv[0] = '{1'b0, 16'h0150, 8'h00, 8'h3C, 1'b1, 1'b1, 1'b1};
        tv[1] = '{1'b1, 16'hC010, 8'hA5, 8'h00, 1'b0, 1'b0, 1'b0};
        tv[2] = '{1'b0, 16'h7FFF, 8'h00, 8'h81, 1'b1, 1'b1, 1'b1};
        tv[3] = '{1'b0, 16'h8000, 8'h00, 8'h42, 1'b0, 1'b0, 1'b1};
        tv[4] = '{1'b1, 16'h9FFF, 8'h5E, 8'h00, 1'b0, 1'b0, 1'b0};
        tv[5] = '{1'b0, 16'hA000, 8'h00, 8'h99, 1'b1, 1'b1, 1'b1};
        tv[6] = '{1'b1, 16'hBFFF, 8'hC3, 8'h00, 1'b1, 1'b1, 1'b0};
        tv[7] = '{1'b0, 16'hC000, 8'h00, 8'h07, 1'b0, 1'b0, 1'b1};

        rstn = 0;
        bi0.cpu_req = 0; bi0.cpu_we = 0; bi0.cpu_addr = 0; bi0.cpu_wdata = 0;
        bi0.dma_req = 0; bi0.dma_addr = 0; bi0.ppu_req = 0; bi0.ppu_addr = 0; bi0.din = 0;
        bi1.cpu_req = 0; bi1.cpu_we = 0; bi1.cpu_addr = 0; bi1.cpu_wdata = 0;
        bi1.dma_req = 0; bi1.dma_addr = 0; bi1.ppu_req = 0; bi1.ppu_addr = 0; bi1.din = 0;
        repeat (3) step();
        rstn = 1;

        // Table-driven single CPU accesses.
        for (int i = 0; i < 8; i++) begin
            align(2'd3);
            bi0.cpu_req = 1; bi0.cpu_we = tv[i].we;
            bi0.cpu_addr = tv[i].addr; bi0.cpu_wdata = tv[i].wdata;
            @(negedge clk);
            chk("tv_gnt", bi0.cpu_gnt, 1);
            step();
            bi0.cpu_req = 0;
            @(negedge clk);
            chk("tv_ph0", {bi0.a, bi0.cale}, {tv[i].addr, tv[i].cale});
            step();
            step();
            bi0.din = tv[i].din;
            @(negedge clk);
            chk("tv_ph2", {bi0.a, bi0.dout, bi0.doe, bi0.wr, bi0.cs},
                {tv[i].addr, tv[i].we ? tv[i].wdata : 8'hFF, tv[i].we, tv[i].we, tv[i].cs});
            step();
            @(negedge clk);
            chk("tv_rv", bi0.cpu_rvalid, tv[i].rv);
            if (tv[i].rv) chk("tv_rdata", bi0.cpu_rdata, tv[i].din);
        end

        // Reset mid-frame aborts an in-flight read.
        align(2'd3);
        bi0.cpu_req = 1; bi0.cpu_we = 0; bi0.cpu_addr = 16'h0150;
        step();
        bi0.cpu_req = 0;
        step();
        step();
        rstn = 0;
        repeat (3) step();
        rstn = 1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("rst_seq_ct", bi0.ct, k % 4);
            chk("rst_norv", bi0.cpu_rvalid, 0);
            step();
        end

        // Contention: u0 favours DMA, u1 favours CPU.
        align(2'd3);
        bi0.cpu_req = 1; bi0.cpu_we = 0; bi0.cpu_addr = 16'h0200;
        bi0.dma_req = 1; bi0.dma_addr = 16'hC100;
        bi1.cpu_req = 1; bi1.cpu_we = 0; bi1.cpu_addr = 16'h0200;
        bi1.dma_req = 1; bi1.dma_addr = 16'hC100;
        for (int f = 0; f < 2; f++) begin
            if (f > 0) align(2'd3);
            @(negedge clk);
            chk("cont0_a", {bi0.cpu_gnt, bi0.dma_gnt}, 2'b01);
            chk("cont1_a", {bi1.cpu_gnt, bi1.dma_gnt}, 2'b10);
            step();
            bi0.dma_addr = 16'hC101;
            bi1.cpu_addr = 16'h0201;
        end
        bi0.dma_req = 0;
        bi1.cpu_req = 0;
        align(2'd3);
        @(negedge clk);
        chk("cont0_b", {bi0.cpu_gnt, bi0.dma_gnt}, 2'b10);
        chk("cont1_b", {bi1.cpu_gnt, bi1.dma_gnt}, 2'b01);
        step();
        bi0.cpu_req = 0;
        bi1.dma_req = 0;

        // PPU streaming reads.
        align(2'd0);
        bi0.ppu_req = 1; bi0.ppu_addr = 13'h1800;
        for (int i = 0; i < 8; i++) begin
            if (i % 4 == 1) bi0.din = 8'h11;
            if (i % 4 == 3) bi0.din = 8'h22;
            @(negedge clk);
            if (i % 4 == 1 || i % 4 == 3) chk("ppu_a", bi0.a, 16'h9800);
            if (i % 4 == 2) chk("ppu_rv1", {bi0.ppu_rvalid, bi0.ppu_rdata}, {1'b1, 8'h11});
            if (i % 4 == 0 && i > 0) chk("ppu_rv3", {bi0.ppu_rvalid, bi0.ppu_rdata}, {1'b1, 8'h22});
            step();
        end
        bi0.ppu_req = 0;

        // Back-to-back CPU reads with req held.
        align(2'd3);
        bi0.cpu_req = 1; bi0.cpu_we = 0; bi0.cpu_addr = 16'h4000;
        @(negedge clk);
        chk("b2b_g1", bi0.cpu_gnt, 1);
        step();
        bi0.cpu_addr = 16'h4001;
        step();
        step();
        bi0.din = 8'h5A;
        step();
        @(negedge clk);
        chk("b2b_g2", {bi0.cpu_gnt, bi0.cpu_rvalid, bi0.cpu_rdata}, {1'b1, 1'b1, 8'h5A});
        step();
        bi0.cpu_req = 0;
        step();
        step();
        bi0.din = 8'h6B;
        step();
        @(negedge clk);
        chk("b2b_r2", {bi0.cpu_gnt, bi0.cpu_rvalid, bi0.cpu_rdata}, {1'b0, 1'b1, 8'h6B});

        // Random traffic, including occasional resets, checked by the model.
        cacc = 0; dacc = 0; pacc = 0; rcnt = 0;
        for (int k = 0; k < 3000; k++) begin
            step();
            if (rcnt > 0) begin
                rstn = 0;
                rcnt--;
            end else begin
                rstn = 1;
                if ($urandom_range(0, 299) == 0) begin
                    rstn = 0;
                    rcnt = $urandom_range(0, 2);
                end
            end
            if (!bi0.cpu_req || cacc) begin
                bi0.cpu_req   = ($urandom_range(0, 2) == 0);
                bi0.cpu_we    = 1'($urandom);
                bi0.cpu_addr  = 16'($urandom);
                bi0.cpu_wdata = 8'($urandom);
            end else if ($urandom_range(0, 15) == 0) bi0.cpu_req = 0;
            if (!bi0.dma_req || dacc) begin
                bi0.dma_req  = ($urandom_range(0, 2) == 0);
                bi0.dma_addr = 16'($urandom);
            end else if ($urandom_range(0, 15) == 0) bi0.dma_req = 0;
            if (!bi0.ppu_req || pacc) begin
                bi0.ppu_req  = 1'($urandom);
                bi0.ppu_addr = 13'($urandom);
            end
            bi0.din = 8'($urandom);
            @(negedge clk);
            cacc = bi0.cpu_gnt;
            dacc = bi0.dma_gnt;
            pacc = bi0.ppu_gnt;
        end
        step();
        rstn = 1;
        bi0.cpu_req = 0; bi0.dma_req = 0; bi0.ppu_req = 0;
        repeat (6) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
